// File: rtl/address_generator_if.sv
// Address/control bundle between the layer sequencer and the weight ROM,
// neuron RAM and MAC core.
interface address_generator_if;
  logic [7:0] read_weight_base_addr;
  logic [7:0] read_neuro_base_addr;
  logic [7:0] write_neuro_base_addr;
  logic [7:0] neuro_read_addr;
  logic [7:0] weight_read_addr;
  logic [7:0] neuro_write_addr;
  logic       read;
  logic       neuron_finished;
  logic       forget;
  logic       alu_rst;
  logic       finished;

  modport master (
    input  read_weight_base_addr, read_neuro_base_addr, write_neuro_base_addr,
    output neuro_read_addr, weight_read_addr, neuro_write_addr,
    output read, neuron_finished, forget, alu_rst, finished
  );

  modport slave (
    output read_weight_base_addr, read_neuro_base_addr, write_neuro_base_addr,
    input  neuro_read_addr, weight_read_addr, neuro_write_addr,
    input  read, neuron_finished, forget, alu_rst, finished
  );
endinterface

// File: rtl/address_generator.sv
// Layer sequencer: walks Nk inputs x Nn neurons once per reset release and
// drives neuron/weight address streams plus MAC accumulator control.
module address_generator #(
  parameter logic [7:0] INSTR_NK = 8'd4,
  parameter logic [7:0] INSTR_NN = 8'd2
) (
  input  logic                 clk,
  input  logic                 reset,
  address_generator_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_r;
  state_t     state_next_s;
  logic [7:0] nk_r;
  logic [7:0] nn_r;
  logic [7:0] i_r;
  logic [7:0] j_r;
  logic [7:0] w_r;
  logic [1:0] forget_r;
  logic       finished_r;
  logic       last_input_s;
  logic       last_neuron_s;

  // Read-only instruction table; words 2 and 3 are unused and read as zero.
  function automatic logic [7:0] instr_word(input logic [1:0] addr);
    logic [7:0] word_s;
    case (addr)
      2'd0:    word_s = INSTR_NK;
      2'd1:    word_s = INSTR_NN;
      default: word_s = 8'd0;
    endcase
    return word_s;
  endfunction

  assign last_input_s  = (i_r == (nk_r - 8'd1));
  assign last_neuron_s = (j_r == (nn_r - 8'd1));

  // Next-state logic; INIT decides on the table words directly since nk/nn latch on that edge.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        state_next_s = INIT;
      end
      INIT: begin
        if ((instr_word(2'd0) != 8'd0) && (instr_word(2'd1) != 8'd0)) begin
          state_next_s = RUN;
        end else begin
          state_next_s = DONE;
        end
      end
      RUN: begin
        if (last_input_s && last_neuron_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        state_next_s = DONE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, finished flag and the two-stage forget pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      finished_r <= 1'b0;
      forget_r   <= 2'b00;
    end else begin
      state_r    <= state_next_s;
      finished_r <= (state_next_s == DONE);
      forget_r   <= {forget_r[0], bus.neuron_finished};
    end
  end

  // Geometry latch and input/neuron/weight counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nk_r <= 8'd0;
      nn_r <= 8'd0;
      i_r  <= 8'd0;
      j_r  <= 8'd0;
      w_r  <= 8'd0;
    end else begin
      case (state_r)
        INIT: begin
          nk_r <= instr_word(2'd0);
          nn_r <= instr_word(2'd1);
          i_r  <= 8'd0;
          j_r  <= 8'd0;
          w_r  <= 8'd0;
        end
        RUN: begin
          w_r <= w_r + 8'd1;
          if (last_input_s) begin
            i_r <= 8'd0;
            j_r <= j_r + 8'd1;
          end else begin
            i_r <= i_r + 8'd1;
          end
        end
        default: begin
          i_r <= i_r;
        end
      endcase
    end
  end

  // Address sums wrap modulo 256 by truncation; bases act immediately.
  assign bus.neuro_read_addr  = bus.read_neuro_base_addr + i_r;
  assign bus.weight_read_addr = bus.read_weight_base_addr + w_r;
  assign bus.neuro_write_addr = bus.write_neuro_base_addr + j_r;
  assign bus.read             = (state_r == RUN);
  assign bus.neuron_finished  = (state_r == RUN) && last_input_s;
  assign bus.alu_rst          = (state_r == IDLE) || (state_r == INIT);
  assign bus.finished         = finished_r;
  assign bus.forget           = forget_r[1];

endmodule

// File: tb/tb_address_generator.sv
// Directed bench for address_generator: three instances (Nk/Nn = 4/2, 1/3, 0/2)
// share clock and reset; expectations are computed from cycle numbers.
module tb_address_generator;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  address_generator_if ia ();
  address_generator_if ib ();
  address_generator_if ic ();

  address_generator #(.INSTR_NK(8'd4), .INSTR_NN(8'd2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ia.master)
  );

  address_generator #(.INSTR_NK(8'd1), .INSTR_NN(8'd3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ib.master)
  );

  address_generator #(.INSTR_NK(8'd0), .INSTR_NN(8'd2)) dut_c (
    .clk   (clk),
    .reset (reset),
    .bus   (ic.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs of all three instances in cycle cyc (0 = INIT).
  task automatic check_cycle(input int cyc, input logic [7:0] rbase);
    int         k;
    logic [7:0] e8;
    k = cyc - 1;
    chk("a_alu_rst",  32'(ia.alu_rst),  32'(cyc == 0));
    chk("a_read",     32'(ia.read),     32'(cyc >= 1 && cyc <= 8));
    chk("a_finished", 32'(ia.finished), 32'(cyc >= 9));
    chk("a_forget",   32'(ia.forget),   32'(cyc == 6 || cyc == 10));
    if (cyc >= 1 && cyc <= 8) begin
      e8 = rbase + 8'(k % 4);
      chk("a_nra", 32'(ia.neuro_read_addr),  32'(e8));
      chk("a_wra", 32'(ia.weight_read_addr), 32'(k));
      chk("a_nwa", 32'(ia.neuro_write_addr), 32'(10 + k / 4));
      chk("a_nf",  32'(ia.neuron_finished),  32'(k % 4 == 3));
    end else begin
      chk("a_nf_idle", 32'(ia.neuron_finished), 32'd0);
      if (cyc == 0) begin
        chk("a_nra_init", 32'(ia.neuro_read_addr),  32'(rbase));
        chk("a_wra_init", 32'(ia.weight_read_addr), 32'd0);
      end
    end
    chk("b_nf",       32'(ib.neuron_finished), 32'(cyc >= 1 && cyc <= 3));
    chk("b_finished", 32'(ib.finished),        32'(cyc >= 4));
    chk("b_forget",   32'(ib.forget),          32'(cyc >= 3 && cyc <= 5));
    if (cyc >= 1 && cyc <= 3) begin
      chk("b_nwa", 32'(ib.neuro_write_addr), 32'(10 + k));
    end
    chk("c_finished", 32'(ic.finished),        32'(cyc >= 1));
    chk("c_nf",       32'(ic.neuron_finished), 32'd0);
    chk("c_forget",   32'(ic.forget),          32'd0);
    chk("c_read",     32'(ic.read),            32'd0);
  endtask

  task automatic run_layer(input int ncyc, input logic [7:0] rbase);
    @(negedge clk);
    reset = 1'b1;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      check_cycle(cyc, rbase);
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b0;
    ia.read_weight_base_addr = 8'd5;
    ia.read_neuro_base_addr  = 8'd7;
    ia.write_neuro_base_addr = 8'd9;
    ib.read_weight_base_addr = 8'd0;
    ib.read_neuro_base_addr  = 8'd0;
    ib.write_neuro_base_addr = 8'd10;
    ic.read_weight_base_addr = 8'd0;
    ic.read_neuro_base_addr  = 8'd0;
    ic.write_neuro_base_addr = 8'd0;

    // Reset state held over several clocks.
    repeat (3) @(negedge clk);
    chk("rst_wra",      32'(ia.weight_read_addr), 32'd5);
    chk("rst_nra",      32'(ia.neuro_read_addr),  32'd7);
    chk("rst_nwa",      32'(ia.neuro_write_addr), 32'd9);
    chk("rst_read",     32'(ia.read),             32'd0);
    chk("rst_finished", 32'(ia.finished),         32'd0);
    chk("rst_nf",       32'(ia.neuron_finished),  32'd0);
    chk("rst_forget",   32'(ia.forget),           32'd0);
    chk("rst_alu_rst",  32'(ia.alu_rst),          32'd1);

    // Basic layer.
    ia.read_weight_base_addr = 8'd0;
    ia.read_neuro_base_addr  = 8'd0;
    ia.write_neuro_base_addr = 8'd10;
    run_layer(12, 8'd0);

    // Read-base wrap.
    @(negedge clk);
    reset = 1'b0;
    ia.read_neuro_base_addr = 8'hFE;
    run_layer(12, 8'hFE);

    // Reset asserted at cycle 3, then a full rerun.
    @(negedge clk);
    reset = 1'b0;
    ia.read_neuro_base_addr = 8'd0;
    run_layer(4, 8'd0);
    reset = 1'b0;
    #1;
    chk("mid_read",     32'(ia.read),             32'd0);
    chk("mid_alu_rst",  32'(ia.alu_rst),          32'd1);
    chk("mid_nra",      32'(ia.neuro_read_addr),  32'd0);
    chk("mid_wra",      32'(ia.weight_read_addr), 32'd0);
    chk("mid_nwa",      32'(ia.neuro_write_addr), 32'd10);
    chk("mid_nf",       32'(ia.neuron_finished),  32'd0);
    chk("mid_b_forget", 32'(ib.forget),           32'd0);
    chk("mid_b_nwa",    32'(ib.neuro_write_addr), 32'd10);
    chk("mid_c_fin",    32'(ic.finished),         32'd0);
    run_layer(12, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/address_generator.md
# address_generator

Sequencing core of the neural accelerator. It holds a small instruction table giving layer geometry (Nk inputs per neuron, Nn neurons) and a control FSM. It also drives the read/write address streams that feed the weight ROM, the neuron dual-port RAM and the MAC core, plus the MAC accumulator control pulses (`alu_rst`, `forget`). One layer is evaluated per reset release; `finished` then latches high.

## Interface
- `INSTR_NK`, default 4: instruction word 0, inputs per neuron (Nk), 8-bit.
- `INSTR_NN`, default 2: instruction word 1, neurons in layer (Nn), 8-bit.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset (0 = reset).
- `read_weight_base_addr`  in  8: weight ROM base; sampled continuously.
- `read_neuro_base_addr`  in  8: neuron RAM input-vector base.
- `write_neuro_base_addr`  in  8: neuron RAM output-vector base.
- `neuro_read_addr`  out  8: current input address.
- `weight_read_addr`  out  8: current weight address.
- `neuro_write_addr`  out  8: current output-neuron address.
- `read`  out  1: high while addresses are valid (RUN state).
- `neuron_finished`  out  1: one-cycle pulse on the last input of each neuron.
- `forget`  out  1: `neuron_finished` delayed exactly 2 clocks; clears the MAC accumulator.
- `alu_rst`  out  1: active-high MAC reset.
- `finished`  out  1: layer complete; sticky until reset.

## Operation
- Instruction table: 4 words × 8 bits, read-only. Word 0 is `INSTR_NK`, word 1 is `INSTR_NN`, and words 2–3 are 0. It is read combinationally.
- FSM states are IDLE, INIT, RUN and DONE.
  - IDLE: held while `reset`=0.
  - IDLE→INIT: first edge after reset release.
  - INIT lasts 1 cycle. It latches Nk and Nn from words 0 and 1 and clears counters.
  - INIT→RUN if Nk≠0 and Nn≠0; otherwise INIT→DONE.
  - RUN→DONE: on the edge where i=Nk−1 and j=Nn−1.
  - DONE: terminal.
- Counters (8-bit): i is the input index, j is the neuron index, w is the flat weight index.
- On each RUN edge:
  - w←w+1.
  - If i=Nk−1: i←0 and j←j+1.
  - Otherwise: i←i+1.
- Address outputs are combinational from the registers, all modulo 256:
  - `neuro_read_addr` = read_neuro_base_addr+i.
  - `weight_read_addr` = read_weight_base_addr+w.
  - `neuro_write_addr` = write_neuro_base_addr+j.
- `neuron_finished` = (state==RUN && i==Nk−1), combinational.
- `read` = (state==RUN).
- `alu_rst` = 1 in IDLE and INIT, 0 otherwise.
- `finished` = (state==DONE), registered.
- `forget` is a 2-stage register pipeline of `neuron_finished`. It keeps shifting in DONE, so the final pulse is delivered.

## Timing
- Reset values (async, immediate):
  - state IDLE; i, j, w = 0; forget pipeline = 0.
  - Addresses therefore equal their bases.
  - `read`=0, `neuron_finished`=0, `forget`=0, `finished`=0, `alu_rst`=1.
- Cycle 0 is the first cycle after the first post-reset edge (INIT). RUN begins at cycle 1 with i=j=w=0.
- Latency: first valid address 1 cycle after the first post-reset edge.
- Layer duration: Nk·Nn RUN cycles. `finished` rises at cycle 1+Nk·Nn.
- `forget` pulses 2 cycles after each `neuron_finished` pulse.
- Nk=1: `neuron_finished` is high every RUN cycle and j increments every cycle.
- Nk·Nn>256: w wraps mod 256.
  - Weight addresses wrap mod 256; no error is flagged.
  - Base+index sums also wrap.
- Base inputs changing mid-layer: take effect on the addresses immediately (combinational).
- Reset asserted mid-layer: all state clears immediately and the `forget` pipeline is flushed. A new layer starts after release.

## Test plan
1. Basic layer: Nk=4, Nn=2, bases weight 0 / read 0 / write 10; release reset.
   - Cycle 0: INIT with `alu_rst`=1.
   - Cycles 1–8:
     - `neuro_read_addr` 0,1,2,3,0,1,2,3.
     - `weight_read_addr` 0..7.
     - `neuro_write_addr` 10×4 then 11×4.
   - `neuron_finished` at cycles 4 and 8; `forget` at cycles 6 and 10.
   - `finished`=1 and `read`=0 from cycle 9 onward.
2. Reset state: hold `reset`=0 for 3 cycles with bases 5/7/9.
   - Addresses read 5/7/9 (weight/read/write bases respectively).
   - `read`=`finished`=`neuron_finished`=`forget`=0, `alu_rst`=1.
3. Nk=1, Nn=3:
   - `neuron_finished` high on cycles 1–3.
   - Write address steps 10,11,12.
   - `finished` at cycle 4.
4. Nk=0 (or Nn=0): INIT→DONE.
   - `finished`=1 at cycle 1.
   - No `neuron_finished` or `forget` pulses ever.
5. Wrap: read base 0xFE, Nk=4 → `neuro_read_addr` 0xFE,0xFF,0x00,0x01.
6. Reset asserted at cycle 3 of test 1:
   - Outputs return to their reset values within the same cycle (asynchronous).
   - After release, the sequence repeats exactly as in test 1.
